// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC and runs the imem req/ack handshake.
// Latency: one cycle IDLE after reset, then one instruction per two cycles on zero-wait memory.
// Backpressure: stalls in HOLD until decode takes the word. A redirect while a request is unacked drains it first.
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        trap_valid,
    output logic [31:0] trap_addr,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        misaligned;
    logic [31:0] target;

    assign misaligned  = redirect_addr[1:0] != 2'b00;
    assign target      = misaligned ? TRAP_VECTOR : redirect_addr;
    assign imem_req    = (state == FETCH) || (state == DRAIN);
    assign instr_valid = (state == HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            imem_addr     <= RESET_VECTOR;
            instr         <= 32'h0;
            instr_pc      <= 32'h0;
            trap_valid    <= 1'b0;
            trap_addr     <= 32'h0;
            retired_count <= 32'h0;
        end else begin
            trap_valid <= redirect_valid && misaligned;
            if (redirect_valid && misaligned)
                trap_addr <= redirect_addr;

            if (redirect_valid) begin
                pc <= target;
                case (state)
                    // An unacked request cannot be withdrawn, so wait for its ack in DRAIN.
                    FETCH: begin
                        if (imem_ack) imem_addr <= target;
                        else          state     <= DRAIN;
                    end
                    DRAIN: begin
                        if (imem_ack) begin
                            state     <= FETCH;
                            imem_addr <= target;
                        end
                    end
                    default: begin
                        state     <= FETCH;
                        imem_addr <= target;
                    end
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        state     <= FETCH;
                        imem_addr <= pc;
                    end
                    FETCH: begin
                        if (imem_ack) begin
                            instr    <= imem_rdata;
                            instr_pc <= imem_addr;
                            pc       <= imem_addr + 32'd4;
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            retired_count <= retired_count + 32'd1;
                            state         <= FETCH;
                            imem_addr     <= pc;
                        end
                    end
                    DRAIN: begin
                        if (imem_ack) begin
                            state     <= FETCH;
                            imem_addr <= pc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the RISC-V core. It owns the program counter register and drives a request/acknowledge handshake to instruction memory. It presents each fetched instruction and its PC to decode with a valid/ready handshake. It also applies branch/jump redirects from execute, including misaligned-target trap entry and discard of in-flight fetches.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid only with imem_ack
- instr_valid  out  1  instr/instr_pc valid for decode
- instr  out  32  held instruction word
- instr_pc  out  32  address instr was fetched from
- instr_ready  in  1  decode accepts instr this cycle
- redirect_valid  in  1  branch/jump taken, one-cycle strobe
- redirect_addr  in  32  branch/jump target
- trap_valid  out  1  one-cycle pulse, misaligned redirect taken
- trap_addr  out  32  offending target, valid with trap_valid
- retired_count  out  32  count of instr_valid && instr_ready handshakes

## Operation
- Registers: pc (next fetch address), imem_addr (in-flight address), instr, instr_pc, state, trap_addr, retired_count.
- States:
  - IDLE: post-reset, one cycle.
  - FETCH: request outstanding.
  - HOLD: instruction presented to decode.
  - DRAIN: stale request outstanding; its data is discarded.
- imem_req=1 exactly in FETCH and DRAIN. instr_valid=1 exactly in HOLD.
- imem_addr is loaded with the target address on every transition into FETCH. It is unchanged in all other cycles.
- IDLE -> FETCH with imem_addr=pc.
- FETCH, imem_ack=1, no redirect: instr<=imem_rdata, instr_pc<=imem_addr, pc<=imem_addr+4, -> HOLD.
- FETCH, imem_ack=0, no redirect: stay.
- HOLD, instr_ready=1, no redirect: retired_count+1, -> FETCH at pc.
- HOLD, instr_ready=0: stay; instr/instr_pc stable.
- Redirect has priority over all normal transitions. Let T = redirect_addr if T[1:0]==0, else TRAP_VECTOR.
  - IDLE, or HOLD: pc<=T, -> FETCH at T. In HOLD, the held instruction is dropped and not counted, even if instr_ready=1 the same cycle.
  - FETCH with imem_ack=1: rdata discarded, -> FETCH at T.
  - FETCH with imem_ack=0: pc<=T, -> DRAIN. A request is never withdrawn before ack.
  - DRAIN: pc<=T (newest redirect wins), stay DRAIN if no ack. If ack arrives the same cycle, -> FETCH at T.
- DRAIN, imem_ack=1, no redirect: rdata discarded, -> FETCH at pc.
- Misaligned redirect (redirect_addr[1:0]!=0): trap_valid=1 the following cycle, trap_addr=redirect_addr.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000. retired_count wraps at 2^32.

## Timing
- Reset values:
  - Asserting reset_n=0 forces reset values immediately, in any state, including with a request outstanding. No drain is performed; the memory must also be reset.
  - state=IDLE, pc=RESET_VECTOR, imem_addr=RESET_VECTOR.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, trap_valid=0, trap_addr=0, retired_count=0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- First imem_req is asserted in the 2nd rising edge after reset_n deasserts: IDLE for one cycle, then FETCH.
- Zero-wait memory (ack the same cycle as req) gives 1 instruction per 2 cycles when instr_ready is held high.
- Redirect latency: the cycle after redirect_valid, imem_req=1 with imem_addr=T, unless an old request is still pending (DRAIN).
- trap_valid is high for exactly one cycle per misaligned redirect. Back-to-back misaligned redirects give back-to-back pulses.

## Test plan
- Reset then ack every request immediately, instr_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - instr_valid every other cycle.
  - retired_count=3 after third handshake.
- Hold instr_ready=0 for 5 cycles in HOLD: instr and instr_pc stable, imem_req=0, retired_count unchanged.
- Redirect to 0x200 while FETCH of 0x8 is waiting, ack 3 cycles later:
  - 0x8 data is never presented.
  - imem_addr stays 0x8 until ack.
  - The next fetch is 0x200, then instr_pc=0x200.
- Two redirects in DRAIN (0x300 then 0x400) before ack: the next fetch is 0x400.
- Redirect to 0x202: trap_valid pulses 1 cycle with trap_addr=0x202, and the next fetch is 0x100.
- Redirect to 0xFFFF_FFFC and complete fetch: the following fetch address is 0x0. Assert reset_n mid-FETCH: all outputs return to reset values asynchronously.
